// File: rtl/sudoku_judge_if.sv
// Board-state <-> judge link: board snapshot, op count and game-status flags.
interface sudoku_judge_if;
    localparam int unsigned MAP_W = 324;
    localparam int unsigned OP_W  = 16;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned SEC_W = 10;

    logic             inited;
    logic [MAP_W-1:0] cur_map;
    logic [OP_W-1:0]  op_counter;
    logic             win_tag;
    logic             lose_tag;
    logic             busy;
    logic             conflict;
    logic [CNT_W-1:0] empty_cnt;
    logic [SEC_W-1:0] sec_left;

    modport master (
        output inited, cur_map, op_counter,
        input  win_tag, lose_tag, busy, conflict, empty_cnt, sec_left
    );

    modport slave (
        input  inited, cur_map, op_counter,
        output win_tag, lose_tag, busy, conflict, empty_cnt, sec_left
    );
endinterface

// File: rtl/sudoku_judge.sv
// Sudoku game judge: serial row/col/box scan of a board snapshot, win/loss decision.
// Optional game timer enabled by defining JUDGE_TIMEOUT_EN.
module sudoku_judge #(
    parameter logic [15:0] OP_LIMIT     = 16'd200,
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned TIME_LIMIT_S = 600
) (
    input  logic           CLK_100MHz,
    input  logic           RST,
    sudoku_judge_if.slave  bus
);
    localparam int unsigned MAP_W = 324;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned SEC_W = 10;
    localparam int unsigned IDX_W = 7;

    if (TIME_LIMIT_S >= (1 << SEC_W) || CLK_HZ == 0) begin : g_bad_cfg
        $error("sudoku_judge: TIME_LIMIT_S must fit in 10 bits and CLK_HZ must be nonzero");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_RESULT = 2'd2,
        S_OVER   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [MAP_W-1:0] snap_q, snap_d;
    logic             dirty_q, dirty_d;
    logic             inited_q, inited_d;
    logic [4:0]       g_q, g_d;
    logic [3:0]       p_q, p_d;
    logic [8:0]       seen_q, seen_d;
    logic             empty_flag_q, empty_flag_d;
    logic             conf_flag_q, conf_flag_d;
    logic [CNT_W-1:0] empty_acc_q, empty_acc_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic             busy_q, busy_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] empty_cnt_q, empty_cnt_d;

    logic             map_changed_c;
    logic             time_up_c;
    logic             lose_cond_c;
    logic             win_cond_c;
    logic             scan_done_c;
    logic [4:0]       b_c;
    logic [IDX_W-1:0] idx_c;
    logic [3:0]       val_c;

    assign map_changed_c = (bus.cur_map != snap_q);
    assign lose_cond_c   = bus.inited && ((bus.op_counter >= OP_LIMIT) || time_up_c);
    assign win_cond_c    = !empty_flag_q && !conf_flag_q;
    assign scan_done_c   = (g_q == 5'd26) && (p_q == 4'd8);

    // Map (group, position) to a row-major cell index
    always_comb begin
        b_c   = g_q - 5'd18;
        idx_c = '0;
        if (g_q < 5'd9) begin
            idx_c = 7'(g_q) * 7'd9 + 7'(p_q);
        end else if (g_q < 5'd18) begin
            idx_c = 7'(p_q) * 7'd9 + 7'(g_q - 5'd9);
        end else begin
            idx_c = 7'(b_c / 5'd3) * 7'd27 + 7'(b_c % 5'd3) * 7'd3
                  + 7'(p_q / 4'd3) * 7'd9 + 7'(p_q % 4'd3);
        end
    end

    assign val_c = snap_q[{idx_c, 2'b00} +: 4];

`ifdef JUDGE_TIMEOUT_EN
    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [SEC_W-1:0] sec_left_q, sec_left_d;

    // One-second prescaler and saturating countdown, held in OVER
    always_comb begin
        presc_d    = presc_q;
        sec_left_d = sec_left_q;
        if (!bus.inited) begin
            presc_d    = '0;
            sec_left_d = SEC_W'(TIME_LIMIT_S);
        end else if (state_q != S_OVER) begin
            if (presc_q == PRE_W'(CLK_HZ - 1)) begin
                presc_d = '0;
                if (sec_left_q != '0) begin
                    sec_left_d = sec_left_q - SEC_W'(1);
                end
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    assign time_up_c = (sec_left_d == '0);

    always_ff @(posedge CLK_100MHz) begin
        if (RST) begin
            presc_q    <= '0;
            sec_left_q <= SEC_W'(TIME_LIMIT_S);
        end else begin
            presc_q    <= presc_d;
            sec_left_q <= sec_left_d;
        end
    end

    assign bus.sec_left = sec_left_q;
`else
    assign time_up_c    = 1'b0;
    assign bus.sec_left = '0;
`endif

    always_ff @(posedge CLK_100MHz) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: inited low dominates, then loss, with a RESULT win taking precedence
    always_comb begin
        state_d = state_q;
        if (!bus.inited) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lose_cond_c)  state_d = S_OVER;
                    else if (dirty_q) state_d = S_SCAN;
                end
                S_SCAN: begin
                    if (lose_cond_c)        state_d = S_OVER;
                    else if (map_changed_c) state_d = S_IDLE;
                    else if (scan_done_c)   state_d = S_RESULT;
                end
                S_RESULT: begin
                    if (win_cond_c || lose_cond_c) state_d = S_OVER;
                    else                           state_d = S_IDLE;
                end
                S_OVER:  state_d = S_OVER;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        snap_d       = snap_q;
        dirty_d      = dirty_q;
        inited_d     = bus.inited;
        g_d          = g_q;
        p_d          = p_q;
        seen_d       = seen_q;
        empty_flag_d = empty_flag_q;
        conf_flag_d  = conf_flag_q;
        empty_acc_d  = empty_acc_q;
        win_d        = win_q;
        lose_d       = lose_q;
        conflict_d   = conflict_q;
        empty_cnt_d  = empty_cnt_q;
        busy_d       = (state_d == S_SCAN);

        if (map_changed_c || (bus.inited && !inited_q)) begin
            dirty_d = 1'b1;
        end

        if (!bus.inited) begin
            win_d  = 1'b0;
            lose_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_OVER) begin
                        lose_d = 1'b1;
                    end else if (state_d == S_SCAN) begin
                        snap_d       = bus.cur_map;
                        dirty_d      = 1'b0;
                        g_d          = '0;
                        p_d          = '0;
                        seen_d       = '0;
                        empty_flag_d = 1'b0;
                        conf_flag_d  = 1'b0;
                        empty_acc_d  = '0;
                    end
                end
                S_SCAN: begin
                    if (state_d == S_OVER) begin
                        lose_d = 1'b1;
                    end else if (!map_changed_c) begin
                        if (val_c == 4'd0) begin
                            empty_flag_d = 1'b1;
                            if (g_q < 5'd9) begin
                                empty_acc_d = empty_acc_q + CNT_W'(1);
                            end
                        end else if (val_c > 4'd9) begin
                            conf_flag_d = 1'b1;
                        end else begin
                            if (seen_q[val_c - 4'd1]) begin
                                conf_flag_d = 1'b1;
                            end
                            seen_d[val_c - 4'd1] = 1'b1;
                        end
                        // Group boundary: restart digit tracking
                        if (p_q == 4'd8) begin
                            seen_d = '0;
                            p_d    = '0;
                            g_d    = g_q + 5'd1;
                        end else begin
                            p_d = p_q + 4'd1;
                        end
                    end
                end
                S_RESULT: begin
                    conflict_d  = conf_flag_q;
                    empty_cnt_d = empty_acc_q;
                    if (win_cond_c)       win_d  = 1'b1;
                    else if (lose_cond_c) lose_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (RST) begin
            snap_q       <= '0;
            dirty_q      <= 1'b1;
            inited_q     <= 1'b0;
            g_q          <= '0;
            p_q          <= '0;
            seen_q       <= '0;
            empty_flag_q <= 1'b0;
            conf_flag_q  <= 1'b0;
            empty_acc_q  <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            busy_q       <= 1'b0;
            conflict_q   <= 1'b0;
            empty_cnt_q  <= '0;
        end else begin
            snap_q       <= snap_d;
            dirty_q      <= dirty_d;
            inited_q     <= inited_d;
            g_q          <= g_d;
            p_q          <= p_d;
            seen_q       <= seen_d;
            empty_flag_q <= empty_flag_d;
            conf_flag_q  <= conf_flag_d;
            empty_acc_q  <= empty_acc_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            busy_q       <= busy_d;
            conflict_q   <= conflict_d;
            empty_cnt_q  <= empty_cnt_d;
        end
    end

    assign bus.win_tag   = win_q;
    assign bus.lose_tag  = lose_q;
    assign bus.busy      = busy_q;
    assign bus.conflict  = conflict_q;
    assign bus.empty_cnt = empty_cnt_q;
endmodule

// File: tb/tb_sudoku_judge.sv
// Bench for sudoku_judge: directed scenarios plus randomized boards against a pairwise-rule model.
module tb_sudoku_judge;
    localparam logic [15:0] OP_LIMIT = 16'd200;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] grid [81];
    bit  exp_conf;
    int  exp_empty;
    bit  exp_win;
    bit  prev_conf;
    int  prev_empty;

    sudoku_judge_if bus_if ();

    sudoku_judge #(
        .OP_LIMIT    (OP_LIMIT),
        .CLK_HZ      (100_000_000),
        .TIME_LIMIT_S(600)
    ) dut (
        .CLK_100MHz(clk),
        .RST       (rst),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Valid solution: canonical pattern relabelled by a random digit permutation
    task automatic make_solved();
        int perm [9];
        int j;
        int t;
        for (int i = 0; i < 9; i++) perm[i] = i + 1;
        for (int i = 8; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                grid[r*9+c] = 4'(perm[(r*3 + r/3 + c) % 9]);
    endtask

    task automatic drive_map();
        logic [323:0] m;
        for (int i = 0; i < 81; i++) m[4*i +: 4] = grid[i];
        bus_if.cur_map = m;
    endtask

    // Rules: any value above 9 is a conflict; two equal digits sharing a row, column or box conflict
    function automatic void model();
        bit same;
        exp_conf  = 1'b0;
        exp_empty = 0;
        for (int i = 0; i < 81; i++) begin
            if (grid[i] == 4'd0) exp_empty++;
            else if (grid[i] > 4'd9) exp_conf = 1'b1;
            else begin
                for (int j = i + 1; j < 81; j++) begin
                    same = (i / 9 == j / 9) || (i % 9 == j % 9) ||
                           ((i / 27 == j / 27) && ((i % 9) / 3 == (j % 9) / 3));
                    if (same && grid[j] == grid[i]) exp_conf = 1'b1;
                end
            end
        end
        exp_win = !exp_conf && (exp_empty == 0);
    endfunction

    // Wait for a full scan, check its length, then the outcome one cycle after RESULT
    task automatic run_scan(input bit late_op);
        int  busy_cnt;
        bit  started;
        busy_cnt = 0;
        started  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus_if.busy) begin
                busy_cnt++;
                started = 1'b1;
            end else if (started) begin
                break;
            end
        end
        check("busy_cycles", 32'(busy_cnt), 32'd243);
        check("win_before_result", 32'(bus_if.win_tag), 32'd0);
        if (late_op) bus_if.op_counter = OP_LIMIT;
        step();
        model();
        check("win_tag", 32'(bus_if.win_tag), 32'(exp_win));
        check("lose_tag", 32'(bus_if.lose_tag), 32'(late_op && !exp_win));
        check("conflict", 32'(bus_if.conflict), 32'(exp_conf));
        check("empty_cnt", 32'(bus_if.empty_cnt), 32'(exp_empty));
        prev_conf  = exp_conf;
        prev_empty = exp_empty;
    endtask

    task automatic drop_inited();
        bus_if.inited = 1'b0;
        step();
        check("win_cleared", 32'(bus_if.win_tag), 32'd0);
        check("lose_cleared", 32'(bus_if.lose_tag), 32'd0);
        check("busy_dropped", 32'(bus_if.busy), 32'd0);
        check("conflict_kept", 32'(bus_if.conflict), 32'(prev_conf));
        check("empty_kept", 32'(bus_if.empty_cnt), 32'(prev_empty));
    endtask

    initial begin
        int n;
        int a;
        int b;
        int kind;
        logic [3:0] t;
        bit late;

        prev_conf         = 1'b0;
        prev_empty        = 0;
        rst               = 1'b1;
        bus_if.inited     = 1'b0;
        bus_if.cur_map    = '0;
        bus_if.op_counter = '0;
        repeat (3) step();
        check("rst_win", 32'(bus_if.win_tag), 32'd0);
        check("rst_lose", 32'(bus_if.lose_tag), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_conflict", 32'(bus_if.conflict), 32'd0);
        check("rst_empty", 32'(bus_if.empty_cnt), 32'd0);
        check("rst_sec_left", 32'(bus_if.sec_left), 32'd0);

        // Solved board wins; later board edits are ignored
        rst = 1'b0;
        make_solved();
        drive_map();
        bus_if.inited = 1'b1;
        run_scan(1'b0);
        grid[5] = 4'd0;
        drive_map();
        repeat (3) step();
        check("over_win_sticky", 32'(bus_if.win_tag), 32'd1);
        check("over_no_rescan", 32'(bus_if.busy), 32'd0);

        // Centre cell empty
        drop_inited();
        make_solved();
        grid[40] = 4'd0;
        drive_map();
        bus_if.inited = 1'b1;
        run_scan(1'b0);
        repeat (3) step();
        check("idle_after_empty", 32'(bus_if.busy), 32'd0);

        // Swap cells 0 and 1: column duplicates
        make_solved();
        t = grid[0]; grid[0] = grid[1]; grid[1] = t;
        drive_map();
        run_scan(1'b0);

        // Board edit during scan aborts and restarts
        make_solved();
        drive_map();
        n = 0;
        for (int i = 0; i < 400 && n < 100; i++) begin
            step();
            if (bus_if.busy) n++;
        end
        check("abort_reached_100", 32'(n), 32'd100);
        grid[7] = 4'd0;
        drive_map();
        step();
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_conflict_kept", 32'(bus_if.conflict), 32'(prev_conf));
        check("abort_empty_kept", 32'(bus_if.empty_cnt), 32'(prev_empty));
        run_scan(1'b0);

        // Op limit reached mid-scan on an incomplete board
        drop_inited();
        make_solved();
        grid[3] = 4'd0;
        grid[77] = 4'd0;
        drive_map();
        bus_if.inited = 1'b1;
        repeat (5) step();
        bus_if.op_counter = OP_LIMIT;
        step();
        check("loss_lose", 32'(bus_if.lose_tag), 32'd1);
        check("loss_win", 32'(bus_if.win_tag), 32'd0);
        check("loss_busy", 32'(bus_if.busy), 32'd0);
        grid[10] = 4'd0;
        drive_map();
        repeat (5) step();
        check("loss_sticky", 32'(bus_if.lose_tag), 32'd1);
        bus_if.op_counter = '0;
        drop_inited();

        // One below the op limit does not lose
        make_solved();
        drive_map();
        bus_if.op_counter = OP_LIMIT - 16'd1;
        bus_if.inited = 1'b1;
        run_scan(1'b0);
        bus_if.op_counter = '0;

        // Win and op limit in the same RESULT cycle: win takes it
        drop_inited();
        make_solved();
        drive_map();
        bus_if.inited = 1'b1;
        run_scan(1'b1);
        bus_if.op_counter = '0;

        // Randomized boards
        for (int trial = 0; trial < 12; trial++) begin
            drop_inited();
            make_solved();
            kind = int'($urandom_range(0, 4));
            if (kind == 1 || kind == 4) begin
                n = int'($urandom_range(1, 5));
                for (int k = 0; k < n; k++) grid[$urandom_range(0, 80)] = 4'd0;
            end
            if (kind == 2 || kind == 4) begin
                a = int'($urandom_range(0, 80));
                b = int'($urandom_range(0, 80));
                t = grid[a]; grid[a] = grid[b]; grid[b] = t;
            end
            if (kind == 3) grid[$urandom_range(0, 80)] = 4'($urandom_range(10, 15));
            late = ($urandom_range(0, 3) == 0);
            drive_map();
            bus_if.inited = 1'b1;
            run_scan(late);
            bus_if.op_counter = '0;
        end

        // Reset clears a finished game
        rst = 1'b1;
        step();
        check("rst2_win", 32'(bus_if.win_tag), 32'd0);
        check("rst2_lose", 32'(bus_if.lose_tag), 32'd0);
        check("rst2_conflict", 32'(bus_if.conflict), 32'd0);
        check("rst2_empty", 32'(bus_if.empty_cnt), 32'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
